// File: rtl/axis_averager_sequencer.sv
// -----------------------------------------------------------------------------
// axis_averager_sequencer
//
// Run controller placed in front of axis_complex_averager. It lines averaging
// runs up with upstream frame boundaries and holds the averager in reset
// between runs. It also latches the averaging depth for the length of a run,
// throws away the stale first result frame, and forwards only valid averaged
// frames downstream.
//
// Ports
//   aclk, aresetn      clock; asynchronous active-low reset (released
//                      synchronously inside the block)
//   cfg_start          one-cycle pulse that begins a run (acted on only in IDLE)
//   cfg_stop           one-cycle pulse that aborts a run
//   cfg_continuous     1 = continuous, 0 = single-shot; sampled at start
//   cfg_log_count      averaging depth N (2^N frames); clamped to
//                      LOG_COUNT_MAX and sampled at start
//   S_AXIS_*           upstream complex frames (imag upper, real lower half)
//   avg_aresetn        synchronous reset to the averager; high only in a run
//   avg_log_count      latched N for the averager
//   avg_s_*            stream into the averager slave port
//   avg_m_*            stream from the averager master port
//   O_AXIS_*           averaged frames that are forwarded downstream
//   sts_busy           high while the controller is not IDLE
//   sts_done           one-cycle pulse when a single-shot run completes
//   sts_result_count   count of forwarded result frames since start (wraps)
//   sts_log_count      N of the active or most recent run
//   dbg_state          current controller state (IDLE/ALIGN/RUN/STOPPING)
//
// Handshake rule for every stream: a beat transfers on a rising aclk edge
// where tvalid and tready are both high. A source holds tdata/tlast stable
// while tvalid is high and tready is low. tvalid never depends on tready.
// -----------------------------------------------------------------------------
module axis_averager_sequencer #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int LOG_COUNT_MAX    = 20
) (
  input  logic                        aclk,
  input  logic                        aresetn,

  input  logic                        cfg_start,
  input  logic                        cfg_stop,
  input  logic                        cfg_continuous,
  input  logic [4:0]                  cfg_log_count,

  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                        S_AXIS_tvalid,
  output logic                        S_AXIS_tready,
  input  logic                        S_AXIS_tlast,

  output logic                        avg_aresetn,
  output logic [4:0]                  avg_log_count,

  output logic [AXIS_TDATA_WIDTH-1:0] avg_s_tdata,
  output logic                        avg_s_tvalid,
  input  logic                        avg_s_tready,

  input  logic [AXIS_TDATA_WIDTH-1:0] avg_m_tdata,
  input  logic                        avg_m_tvalid,
  input  logic                        avg_m_tlast,
  output logic                        avg_m_tready,

  output logic [AXIS_TDATA_WIDTH-1:0] O_AXIS_tdata,
  output logic                        O_AXIS_tvalid,
  input  logic                        O_AXIS_tready,
  output logic                        O_AXIS_tlast,

  output logic                        sts_busy,
  output logic                        sts_done,
  output logic [15:0]                 sts_result_count,
  output logic [4:0]                  sts_log_count,

  output logic [1:0]                  dbg_state
);

  // The frame counter has to hold 2^LOG_COUNT_MAX + 1.
  localparam int FW = LOG_COUNT_MAX + 2;
  localparam logic [FW-1:0] F_ONE = FW'(1);
  localparam logic [4:0]    N_MAX = 5'(LOG_COUNT_MAX);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ALIGN    = 2'd1,
    RUN      = 2'd2,
    STOPPING = 2'd3
  } state_t;

  state_t        state;
  logic [4:0]    n_q;
  logic          cont_q;
  logic [FW-1:0] f_cnt;
  logic          in_res;
  logic          fwd_q;

  // ---------------------------------------------------------------------------
  // Reset asserts immediately and releases only after two clean clock edges.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  // ---------------------------------------------------------------------------
  // Combinational datapath steering
  // ---------------------------------------------------------------------------
  logic          active;
  logic          s_last_hs;
  logic          o_last_hs;
  logic          avg_m_hs;
  logic [FW-1:0] m_frames;
  logic [FW-1:0] f_sat;
  logic          f_full;
  logic          fwd_eff;
  logic          gate;
  logic [4:0]    n_clamped;

  assign n_clamped = (cfg_log_count > N_MAX) ? N_MAX : cfg_log_count;

  assign active    = (state == RUN) || (state == STOPPING);
  assign m_frames  = F_ONE << n_q;
  assign f_sat     = m_frames + F_ONE;
  assign f_full    = (f_cnt >= m_frames);

  // The forward decision is made once per result frame, at its first beat,
  // so that F rolling over mid-frame can never split a result frame.
  assign fwd_eff   = in_res ? fwd_q : f_full;
  assign gate      = (state == RUN) && fwd_eff;

  // Upstream: zero-latency passthrough during a run. Outside a run,
  // upstream is drained and its beats are dropped.
  assign avg_s_tdata   = S_AXIS_tdata;
  assign avg_s_tvalid  = active ? S_AXIS_tvalid : 1'b0;
  assign S_AXIS_tready = active ? avg_s_tready  : 1'b1;

  // Downstream: forward gated result frames; stale or unwanted ones are
  // sunk by holding avg_m_tready high.
  assign O_AXIS_tdata  = avg_m_tdata;
  assign O_AXIS_tlast  = avg_m_tlast;
  assign O_AXIS_tvalid = gate ? avg_m_tvalid  : 1'b0;
  assign avg_m_tready  = gate ? O_AXIS_tready : 1'b1;

  assign s_last_hs = S_AXIS_tvalid && S_AXIS_tready && S_AXIS_tlast;
  assign o_last_hs = O_AXIS_tvalid && O_AXIS_tready && O_AXIS_tlast;
  assign avg_m_hs  = avg_m_tvalid && avg_m_tready;

  // The averager is held in reset whenever no run is in progress.
  assign avg_aresetn   = active;
  assign avg_log_count = n_q;
  assign sts_log_count = n_q;
  assign sts_busy      = (state != IDLE);
  assign dbg_state     = state;

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      n_q              <= 5'd0;
      cont_q           <= 1'b0;
      f_cnt            <= '0;
      in_res           <= 1'b0;
      fwd_q            <= 1'b0;
      sts_done         <= 1'b0;
      sts_result_count <= 16'd0;
    end else begin
      sts_done <= 1'b0;

      if (o_last_hs) begin
        sts_result_count <= sts_result_count + 16'd1;
      end

      // Track result-frame boundaries on the averager output.
      if (!active) begin
        in_res <= 1'b0;
        fwd_q  <= 1'b0;
      end else if (avg_m_hs) begin
        if (avg_m_tlast) begin
          in_res <= 1'b0;
        end else if (!in_res) begin
          in_res <= 1'b1;
          fwd_q  <= fwd_eff;
        end
      end

      case (state)
        IDLE: begin
          // A start that arrives together with a stop is ignored.
          if (cfg_start && !cfg_stop) begin
            state            <= ALIGN;
            n_q              <= n_clamped;
            cont_q           <= cfg_continuous;
            f_cnt            <= '0;
            sts_result_count <= 16'd0;
          end
        end

        ALIGN: begin
          f_cnt <= '0;
          if (cfg_stop) begin
            state <= IDLE;
          end else if (s_last_hs) begin
            state <= RUN;
          end
        end

        RUN: begin
          // F saturates one past the depth; from then on every result
          // frame is forwarded.
          if (s_last_hs && (f_cnt != f_sat)) begin
            f_cnt <= f_cnt + F_ONE;
          end
          // Single-shot completion takes priority over a simultaneous stop.
          if (!cont_q && s_last_hs && (f_cnt == m_frames)) begin
            state    <= IDLE;
            sts_done <= 1'b1;
          end else if (cfg_stop) begin
            state <= STOPPING;
          end
        end

        STOPPING: begin
          // Finish the frame in flight so the averager never sees a
          // truncated frame, then drop back to IDLE.
          if (s_last_hs) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_averager_sequencer.sv
// -----------------------------------------------------------------------------
// tb_axis_averager_sequencer
//
// Bench for axis_averager_sequencer. A small behavioural averager stands in
// for axis_complex_averager. During every input frame k*2^N it emits, beat by
// beat, the average of input frames (k-1)*2^N+1 .. k*2^N. Expected output
// frames are worked out separately from the stored input frames with plain
// sums and then queued in exp_q. A negedge monitor pops exp_q for each
// forwarded beat.
// -----------------------------------------------------------------------------
module tb_axis_averager_sequencer;

  localparam int W = 32;
  localparam int L = 8;

  // ---------------------------------------------------------------- clock/reset
  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  logic          cfg_start, cfg_stop, cfg_continuous;
  logic [4:0]    cfg_log_count;
  logic [W-1:0]  S_AXIS_tdata;
  logic          S_AXIS_tvalid, S_AXIS_tready, S_AXIS_tlast;
  logic          avg_aresetn;
  logic [4:0]    avg_log_count;
  logic [W-1:0]  avg_s_tdata;
  logic          avg_s_tvalid, avg_s_tready;
  logic [W-1:0]  avg_m_tdata;
  logic          avg_m_tvalid, avg_m_tlast, avg_m_tready;
  logic [W-1:0]  O_AXIS_tdata;
  logic          O_AXIS_tvalid, O_AXIS_tready, O_AXIS_tlast;
  logic          sts_busy, sts_done;
  logic [15:0]   sts_result_count;
  logic [4:0]    sts_log_count;
  logic [1:0]    dbg_state;

  axis_averager_sequencer #(.AXIS_TDATA_WIDTH(W), .LOG_COUNT_MAX(20)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_continuous(cfg_continuous), .cfg_log_count(cfg_log_count),
    .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tvalid(S_AXIS_tvalid),
    .S_AXIS_tready(S_AXIS_tready), .S_AXIS_tlast(S_AXIS_tlast),
    .avg_aresetn(avg_aresetn), .avg_log_count(avg_log_count),
    .avg_s_tdata(avg_s_tdata), .avg_s_tvalid(avg_s_tvalid),
    .avg_s_tready(avg_s_tready),
    .avg_m_tdata(avg_m_tdata), .avg_m_tvalid(avg_m_tvalid),
    .avg_m_tlast(avg_m_tlast), .avg_m_tready(avg_m_tready),
    .O_AXIS_tdata(O_AXIS_tdata), .O_AXIS_tvalid(O_AXIS_tvalid),
    .O_AXIS_tready(O_AXIS_tready), .O_AXIS_tlast(O_AXIS_tlast),
    .sts_busy(sts_busy), .sts_done(sts_done),
    .sts_result_count(sts_result_count), .sts_log_count(sts_log_count),
    .dbg_state(dbg_state)
  );

  // ------------------------------------------------------------- bookkeeping
  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  logic         mon_last;
  int o_pos;
  int avg_beats;
  int done_cnt;
  logic [W-1:0] fr [0:63][0:L-1];
  int bp_hold = 0;
  bit bp_random = 1'b0;

  // ----------------------------------------------------- behavioural averager
  int sf, sb, m_stub;
  logic [31:0] acc_re [L];
  logic [31:0] acc_im [L];
  logic [31:0] sum_re, sum_im;
  logic emit, grp_start;

  always_comb begin
    m_stub    = 1 << avg_log_count;
    emit      = ((sf % m_stub) == 0);
    grp_start = (sf == 0) || (((sf - 1) % m_stub) == 0);
    sum_re    = (grp_start ? 32'd0 : acc_re[sb]) + {16'd0, avg_s_tdata[15:0]};
    sum_im    = (grp_start ? 32'd0 : acc_im[sb]) + {16'd0, avg_s_tdata[31:16]};
    avg_m_tdata  = {16'(sum_im >> avg_log_count), 16'(sum_re >> avg_log_count)};
    avg_m_tvalid = emit && avg_s_tvalid;
    avg_m_tlast  = (sb == L - 1);
    avg_s_tready = emit ? avg_m_tready : 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (!avg_aresetn) begin
      sf <= 0;
      sb <= 0;
    end else if (avg_s_tvalid && avg_s_tready) begin
      acc_re[sb] <= sum_re;
      acc_im[sb] <= sum_im;
      if (sb == L - 1) begin
        sb <= 0;
        sf <= sf + 1;
      end else begin
        sb <= sb + 1;
      end
    end
  end

  // ----------------------------------------------- downstream backpressure
  initial begin
    O_AXIS_tready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      if (bp_hold > 0) begin
        O_AXIS_tready = 1'b0;
        bp_hold--;
      end else begin
        O_AXIS_tready = bp_random ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // ------------------------------------------------------- scoreboard monitor
  always @(negedge aclk) begin
    if (aresetn) begin
      if (O_AXIS_tvalid && O_AXIS_tready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL o_axis_unexpected: got beat %h, required no beat", O_AXIS_tdata);
        end else begin
          mon_e    = exp_q.pop_front();
          mon_last = ((o_pos % L) == L - 1);
          if (O_AXIS_tdata !== mon_e || O_AXIS_tlast !== mon_last) begin
            fails++;
            $display("FAIL o_axis_beat%0d: got data %h last %b, required data %h last %b",
                     o_pos, O_AXIS_tdata, O_AXIS_tlast, mon_e, mon_last);
          end
        end
        o_pos++;
      end
      if (avg_s_tvalid && avg_s_tready) avg_beats++;
      if (sts_done) done_cnt++;
    end
  end

  // ------------------------------------------------------------ driver tasks
  task automatic send_beat(input logic [W-1:0] d, input logic last);
    bit hs;
    int n;
    S_AXIS_tdata  = d;
    S_AXIS_tvalid = 1'b1;
    S_AXIS_tlast  = last;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 1000) begin
      @(negedge aclk);
      hs = S_AXIS_tready;
      @(posedge aclk); #1;
      cfg_stop  = 1'b0;
      cfg_start = 1'b0;
      n++;
    end
    S_AXIS_tvalid = 1'b0;
    S_AXIS_tlast  = 1'b0;
    if (!hs) begin
      tests++;
      fails++;
      $display("FAIL send_beat_timeout: tready stayed 0, required 1 within 1000 cycles");
    end
  endtask

  task automatic send_align(input int beats);
    for (int i = 0; i < beats; i++) send_beat(W'($urandom), i == beats - 1);
  endtask

  task automatic gen_frames(input int count);
    for (int f = 0; f < count; f++)
      for (int i = 0; i < L; i++)
        fr[f][i] = {16'($urandom_range(0, 4095)), 16'($urandom_range(0, 4095))};
  endtask

  task automatic send_frames(input int first, input int last);
    for (int f = first; f <= last; f++)
      for (int i = 0; i < L; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge aclk); #1;
        end
        send_beat(fr[f][i], i == L - 1);
      end
  endtask

  // Reference: result k (k >= 1) is the average of frames (k-1)M+1 .. kM and
  // is forwarded only if input frame kM is actually fed.
  task automatic compute_expected(input int n, input int frames);
    int m;
    logic [31:0] sre, sim;
    m = 1 << n;
    for (int k = 1; k * m < frames; k++)
      for (int i = 0; i < L; i++) begin
        sre = 0;
        sim = 0;
        for (int f = (k - 1) * m + 1; f <= k * m; f++) begin
          sre += {16'd0, fr[f][i][15:0]};
          sim += {16'd0, fr[f][i][31:16]};
        end
        exp_q.push_back({16'(sim >> n), 16'(sre >> n)});
      end
  endtask

  task automatic start_run(input logic [4:0] n, input logic cont);
    cfg_log_count  = n;
    cfg_continuous = cont;
    exp_q.delete();
    avg_beats = 0;
    done_cnt  = 0;
    o_pos     = 0;
    cfg_start = 1'b1;
    @(posedge aclk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic pulse_stop();
    cfg_stop = 1'b1;
    @(posedge aclk); #1;
    cfg_stop = 1'b0;
  endtask

  task automatic apply_reset();
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    repeat (4) @(posedge aclk);
    #1;
  endtask

  // ----------------------------------------------------------------- tests
  task automatic test_reset();
    tests++; if (avg_aresetn !== 1'b0) begin fails++; $display("FAIL reset_avg_aresetn: got %b, required 0", avg_aresetn); end
    tests++; if (avg_log_count !== 5'd0) begin fails++; $display("FAIL reset_avg_log_count: got %0d, required 0", avg_log_count); end
    tests++; if (sts_busy !== 1'b0 || sts_done !== 1'b0) begin fails++; $display("FAIL reset_sts: got busy %b done %b, required 0 0", sts_busy, sts_done); end
    tests++; if (sts_result_count !== 16'd0 || sts_log_count !== 5'd0) begin fails++; $display("FAIL reset_counts: got %0d %0d, required 0 0", sts_result_count, sts_log_count); end
    tests++; if (O_AXIS_tvalid !== 1'b0 || avg_s_tvalid !== 1'b0) begin fails++; $display("FAIL reset_valids: got %b %b, required 0 0", O_AXIS_tvalid, avg_s_tvalid); end
    tests++; if (S_AXIS_tready !== 1'b1) begin fails++; $display("FAIL reset_s_tready: got %b, required 1", S_AXIS_tready); end
  endtask

  task automatic test_single_shot();
    bp_random = 1'b1;
    start_run(5'd2, 1'b0);
    tests++; if (sts_busy !== 1'b1) begin fails++; $display("FAIL ss_busy_start: got %b, required 1", sts_busy); end
    tests++; if (avg_log_count !== 5'd2) begin fails++; $display("FAIL ss_log_count: got %0d, required 2", avg_log_count); end
    gen_frames(5);
    compute_expected(2, 5);
    send_align(3);
    tests++; if (avg_beats !== 0) begin fails++; $display("FAIL ss_align_discard: got %0d averager beats, required 0", avg_beats); end
    send_frames(0, 4);
    repeat (2) @(posedge aclk); #1;
    tests++; if (exp_q.size() !== 0) begin fails++; $display("FAIL ss_results_missing: got %0d beats outstanding, required 0", exp_q.size()); end
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL ss_done_pulses: got %0d, required 1", done_cnt); end
    tests++; if (sts_result_count !== 16'd1) begin fails++; $display("FAIL ss_result_count: got %0d, required 1", sts_result_count); end
    tests++; if (sts_busy !== 1'b0 || avg_aresetn !== 1'b0) begin fails++; $display("FAIL ss_idle: got busy %b avg_aresetn %b, required 0 0", sts_busy, avg_aresetn); end
    tests++; if (avg_beats !== 5 * L) begin fails++; $display("FAIL ss_avg_beats: got %0d, required %0d", avg_beats, 5 * L); end
    bp_random = 1'b0;
  endtask

  task automatic test_continuous();
    bp_random = 1'b1;
    start_run(5'd1, 1'b1);
    gen_frames(7);
    compute_expected(1, 7);
    send_align(4);
    send_frames(0, 6);
    repeat (2) @(posedge aclk); #1;
    tests++; if (sts_result_count !== 16'd3) begin fails++; $display("FAIL cont_result_count: got %0d, required 3", sts_result_count); end
    tests++; if (sts_busy !== 1'b1) begin fails++; $display("FAIL cont_busy: got %b, required 1", sts_busy); end
    pulse_stop();
    send_align(L);
    tests++; if (sts_busy !== 1'b0) begin fails++; $display("FAIL cont_stop_idle: got busy %b, required 0", sts_busy); end
    tests++; if (exp_q.size() !== 0 || done_cnt !== 0) begin fails++; $display("FAIL cont_end: got %0d outstanding, %0d done, required 0 0", exp_q.size(), done_cnt); end
    bp_random = 1'b0;
  endtask

  task automatic test_log_latch();
    start_run(5'd2, 1'b1);
    cfg_log_count = 5'd5;
    send_align(2);
    gen_frames(1);
    send_frames(0, 0);
    tests++; if (avg_log_count !== 5'd2 || sts_log_count !== 5'd2) begin fails++; $display("FAIL latch_log_count: got %0d %0d, required 2 2", avg_log_count, sts_log_count); end
    pulse_stop();
    send_align(L);
    tests++; if (sts_busy !== 1'b0) begin fails++; $display("FAIL latch_stop_idle: got %b, required 0", sts_busy); end
    start_run(5'd31, 1'b1);
    tests++; if (avg_log_count !== 5'd20) begin fails++; $display("FAIL latch_clamp: got %0d, required 20", avg_log_count); end
    pulse_stop();
    tests++; if (sts_busy !== 1'b0) begin fails++; $display("FAIL align_stop_idle: got %b, required 0", sts_busy); end
  endtask

  task automatic test_stop();
    start_run(5'd2, 1'b0);
    gen_frames(3);
    send_align(5);
    send_frames(0, 1);
    for (int i = 0; i < L; i++) begin
      if (i == 3) cfg_stop = 1'b1;
      send_beat(fr[2][i], i == L - 1);
    end
    tests++; if (sts_busy !== 1'b0 || avg_aresetn !== 1'b0) begin fails++; $display("FAIL stop_idle: got busy %b avg_aresetn %b, required 0 0", sts_busy, avg_aresetn); end
    repeat (2) @(posedge aclk); #1;
    tests++; if (done_cnt !== 0) begin fails++; $display("FAIL stop_no_done: got %0d, required 0", done_cnt); end
    tests++; if (avg_beats !== 3 * L) begin fails++; $display("FAIL stop_avg_beats: got %0d, required %0d", avg_beats, 3 * L); end
  endtask

  task automatic test_backpressure();
    start_run(5'd0, 1'b1);
    gen_frames(3);
    compute_expected(0, 3);
    fork
      begin
        send_align(5);
        send_frames(0, 2);
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
          @(negedge aclk);
          seen = O_AXIS_tvalid && O_AXIS_tready;
        end
        if (!seen) begin
          tests++; fails++;
          $display("FAIL bp_no_forward: got no forwarded beat, required one within 3000 cycles");
        end else begin
          bp_hold = 10;
          @(posedge aclk); #2;
          for (int c = 0; c < 10; c++) begin
            @(negedge aclk);
            tests++;
            if (S_AXIS_tready !== 1'b0) begin
              fails++;
              $display("FAIL bp_s_tready_c%0d: got %b, required 0", c, S_AXIS_tready);
            end
          end
        end
      end
    join
    repeat (2) @(posedge aclk); #1;
    tests++; if (exp_q.size() !== 0 || sts_result_count !== 16'd2) begin fails++; $display("FAIL bp_results: got %0d outstanding, count %0d, required 0 2", exp_q.size(), sts_result_count); end
    pulse_stop();
    send_align(L);
  endtask

  task automatic test_collisions();
    start_run(5'd0, 1'b0);
    gen_frames(2);
    compute_expected(0, 2);
    send_align(1);
    send_frames(0, 0);
    for (int i = 0; i < L - 1; i++) send_beat(fr[1][i], 1'b0);
    cfg_stop = 1'b1;
    send_beat(fr[1][L-1], 1'b1);
    repeat (2) @(posedge aclk); #1;
    tests++; if (done_cnt !== 1 || sts_busy !== 1'b0) begin fails++; $display("FAIL coll_done_wins: got done %0d busy %b, required 1 0", done_cnt, sts_busy); end
    tests++; if (sts_result_count !== 16'd1 || exp_q.size() !== 0) begin fails++; $display("FAIL coll_result: got count %0d outstanding %0d, required 1 0", sts_result_count, exp_q.size()); end
    cfg_log_count = 5'd3;
    cfg_start = 1'b1;
    cfg_stop  = 1'b1;
    @(posedge aclk); #1;
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
    tests++; if (sts_busy !== 1'b0 || sts_log_count !== 5'd0) begin fails++; $display("FAIL coll_start_stop: got busy %b log %0d, required 0 0", sts_busy, sts_log_count); end
  endtask

  task automatic test_reset_mid_run();
    start_run(5'd1, 1'b1);
    gen_frames(3);
    compute_expected(1, 3);
    send_align(2);
    send_frames(0, 1);
    for (int i = 0; i < 4; i++) send_beat(fr[2][i], 1'b0);
    S_AXIS_tdata  = fr[2][4];
    S_AXIS_tvalid = 1'b1;
    @(negedge aclk);
    tests++; if (O_AXIS_tvalid !== 1'b1) begin fails++; $display("FAIL rst_forwarding: got O_AXIS_tvalid %b, required 1", O_AXIS_tvalid); end
    #1 aresetn = 1'b0;
    #1;
    tests++; if (O_AXIS_tvalid !== 1'b0 || avg_s_tvalid !== 1'b0) begin fails++; $display("FAIL rst_mid_valids: got %b %b, required 0 0", O_AXIS_tvalid, avg_s_tvalid); end
    tests++; if (avg_aresetn !== 1'b0 || sts_busy !== 1'b0 || sts_done !== 1'b0) begin fails++; $display("FAIL rst_mid_ctrl: got %b %b %b, required 0 0 0", avg_aresetn, sts_busy, sts_done); end
    tests++; if (avg_log_count !== 5'd0 || S_AXIS_tready !== 1'b1) begin fails++; $display("FAIL rst_mid_misc: got log %0d tready %b, required 0 1", avg_log_count, S_AXIS_tready); end
    S_AXIS_tvalid = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    repeat (4) @(posedge aclk);
    #1;
    start_run(5'd1, 1'b1);
    gen_frames(3);
    compute_expected(1, 3);
    send_align(6);
    send_frames(0, 2);
    repeat (2) @(posedge aclk); #1;
    tests++; if (sts_result_count !== 16'd1 || exp_q.size() !== 0) begin fails++; $display("FAIL rst_rerun: got count %0d outstanding %0d, required 1 0", sts_result_count, exp_q.size()); end
    pulse_stop();
    send_align(L);
    tests++; if (sts_busy !== 1'b0) begin fails++; $display("FAIL rst_rerun_idle: got %b, required 0", sts_busy); end
  endtask

  // ------------------------------------------------------------ sequencing
  initial begin
    cfg_start = 1'b0; cfg_stop = 1'b0; cfg_continuous = 1'b0; cfg_log_count = 5'd0;
    S_AXIS_tdata = '0; S_AXIS_tvalid = 1'b0; S_AXIS_tlast = 1'b0;
    avg_beats = 0; done_cnt = 0; o_pos = 0;
    apply_reset();
    test_reset();
    test_single_shot();
    test_continuous();
    test_log_latch();
    test_stop();
    test_backpressure();
    test_collisions();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
